// File: rtl/dac_nch_sequencer.sv
// rtl/dac_nch_sequencer.sv - N-channel SPI DAC write sequencer with continuous refresh and eow watchdog
module dac_nch_sequencer #(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1024,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cont_i,
  input  logic [NCH-1:0]    chmask_i,
  input  logic [NCH*DW-1:0] data_i,
  input  logic              eow_i,
  output logic              strw_o,
  output logic [CW-1:0]     selch_o,
  output logic [DW-1:0]     data_o,
  output logic              eod_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o
);

  // Watchdog counts 0..TIMEOUT-1; the last value is where the abort fires.
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] WD_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [NCH-1:0]      mask_q;
  logic [NCH*DW-1:0]   data_q;
  logic [CW-1:0]       sel_q;
  logic [CNTW-1:0]     wd_q;
  logic                timeout_q;

  logic                capture;
  logic                wd_expire;
  logic [NCH-1:0]      mask_left;

  // Lowest set bit of a mask; callers guarantee the mask is non-zero.
  function automatic logic [CW-1:0] lowest_set(input logic [NCH-1:0] m);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CW'(i);
    end
  endfunction

  // Capture, remaining-channel and watchdog-expiry decodes shared by FSM and datapath.
  always_comb begin
    capture   = ((state_q == S_IDLE && start_i) || (state_q == S_DONE && cont_i))
                && (chmask_i != '0);
    mask_left = mask_q & ~(NCH'(1) << sel_q);
    wd_expire = (TIMEOUT != 0) && (state_q == S_WAIT) && !eow_i && (wd_q == WD_LAST);
  end

  // State register; asynchronous reset aborts any sweep in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; eow in the final watchdog cycle takes priority over the abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (capture) state_d = S_STROBE;
      S_STROBE: state_d = S_WAIT;
      S_WAIT: begin
        if (eow_i)          state_d = (mask_left != '0) ? S_STROBE : S_DONE;
        else if (wd_expire) state_d = S_IDLE;
      end
      S_DONE:   state_d = capture ? S_STROBE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: capture mask/data, walk the mask upward, run the watchdog.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (capture) begin
        mask_q    <= chmask_i;
        data_q    <= data_i;
        sel_q     <= lowest_set(chmask_i);
        timeout_q <= 1'b0;
      end
      if (state_q == S_STROBE) wd_q <= '0;
      if (state_q == S_WAIT) begin
        if (eow_i) begin
          mask_q <= mask_left;
          if (mask_left != '0) sel_q <= lowest_set(mask_left);
        end else if (wd_expire) begin
          timeout_q <= 1'b1;
          mask_q    <= '0;
        end else begin
          wd_q <= wd_q + CNTW'(1);
        end
      end
    end
  end

  // Outputs decoded from registered state only; data_o follows the captured word of selch_o.
  always_comb begin
    strw_o    = (state_q == S_STROBE);
    eod_o     = (state_q == S_IDLE);
    busy_o    = (state_q != S_IDLE);
    done_o    = (state_q == S_DONE);
    selch_o   = sel_q;
    data_o    = data_q[int'(sel_q) * DW +: DW];
    timeout_o = timeout_q;
  end

endmodule
